ucsbece154a_mem_arbiter: RTL and testbench
==========================================

# ucsbece154a_mem_arbiter

Two-requester arbiter that shares one single-port synchronous memory between the processor's instruction-fetch path and its load/store path. It sits between the RISC-V core and a unified instruction/data RAM. It grants at most one access per cycle and routes each read response back to the requester that issued it. Data accesses have priority, and a starvation counter bounds how long a pending fetch can wait.

## Interface
- ADDR_WIDTH, 32, byte-address width; passed to memory unchanged.
- DATA_WIDTH, 32, word width.
- MAX_DATA_BURST, 3, maximum number of consecutive data grants while a fetch is pending (1..15).

- clk  input  1  rising-edge clock; the block uses one clock.
- reset  input  1  asynchronous, active-high reset.
- i_req_i  input  1  fetch request.
- i_addr_i  input  ADDR_WIDTH  fetch byte address.
- i_ready_o  output  1  fetch accepted this cycle.
- i_rvalid_o  output  1  fetch read data valid.
- i_rdata_o  output  DATA_WIDTH  fetch read data.
- d_req_i  input  1  data request.
- d_we_i  input  1  1 = store, 0 = load.
- d_addr_i  input  ADDR_WIDTH  data byte address.
- d_wdata_i  input  DATA_WIDTH  store data.
- d_ready_o  output  1  data request accepted this cycle.
- d_rvalid_o  output  1  load data valid.
- d_rdata_o  output  DATA_WIDTH  load data.
- mem_en_o  output  1  memory access enable.
- mem_we_o  output  1  memory write enable.
- mem_addr_o  output  ADDR_WIDTH  memory address.
- mem_wdata_o  output  DATA_WIDTH  memory write data.
- mem_rdata_i  input  DATA_WIDTH  memory read data, valid one cycle after an enabled read.

## Operation
**Handshake**
- A requester holds req, addr, we and wdata stable until it sees ready=1 in the same cycle.
- A transfer occurs on the clock edge where req=1 and ready=1.
- A requester may present its next request in the cycle immediately after acceptance.

**Grant selection**
- Grant selection is combinational each cycle.
- Only d_req=1: grant data.
- Only i_req=1: grant fetch.
- Both requests: grant data, unless starve_cnt == MAX_DATA_BURST, in which case grant fetch.
- Neither request: no grant; mem_en_o=0.
- Exactly one of i_ready_o or d_ready_o is high on any grant, never both.

**Memory outputs**
- On a grant: mem_en_o=1.
- mem_addr_o = addr of the granted requester.
- mem_we_o = d_we_i when data is granted, otherwise 0.
- mem_wdata_o = d_wdata_i.

**Starvation counter (starve_cnt, 4 bits)**
- Increments on each data grant while i_req_i=1.
- Clears to 0 on any fetch grant or any cycle with i_req_i=0.
- Saturates at MAX_DATA_BURST.

**Response tracking state (resp)**
- States: RESP_NONE, RESP_I, RESP_D.
- Next state is RESP_I after a fetch grant.
- Next state is RESP_D after a load grant.
- Next state is RESP_NONE after a store grant or no grant.

**Response outputs**
- i_rvalid_o = (resp == RESP_I).
- d_rvalid_o = (resp == RESP_D).
- i_rdata_o and d_rdata_o are both driven by mem_rdata_i; rvalid qualifies them.
- Stores produce no rvalid; a store is complete at acceptance.

## Timing
- Acceptance latency is 0 cycles: ready is combinational from req and the current state.
- Read-data latency is exactly 1 cycle after acceptance.
- Throughput is one access per cycle; back-to-back responses alternate correctly between requesters.
- Reset asserted (asynchronous): resp = RESP_NONE and starve_cnt = 0 immediately.
- While reset is high, every output is 0: ready, rvalid, rdata, mem_en, mem_we, mem_addr and mem_wdata.
- Reset mid-operation: any in-flight read response is dropped, and no rvalid appears after reset deasserts.
- The first grant is possible in the first cycle with reset=0.
- A store followed by a load to the same address in the next cycle returns the new data. Ordering is preserved because the memory is single-port and serialized.
- Fetch worst-case wait under continuous data requests: MAX_DATA_BURST cycles, then a guaranteed grant.

## Test plan
1. **Reset:** hold reset=1 with both reqs high -> all outputs 0. Release reset -> d_ready_o=1 in the same cycle.
2. **Lone fetch:** i_req=1, addr=0x10, memory word 0x00500113 -> i_ready_o=1 in cycle N. In cycle N+1: i_rvalid_o=1, i_rdata_o=0x00500113, d_rvalid_o=0.
3. **Store then load:** store 0xBEEF000 to 0x68, then load 0x68 in the next cycle -> mem_we_o=1 only in the first cycle. d_rvalid_o=1 with data 0xBEEF000 one cycle after the load is accepted.
4. **Starvation bound:** MAX_DATA_BURST=3, i_req held high, d_req held high -> grants are D, D, D, I, D, D, D, I… Each fetch response arrives one cycle after its grant.
5. **Alternating responses:** fetch accepted in cycle N, load accepted in cycle N+1 -> i_rvalid_o in N+1 and d_rvalid_o in N+2, each with the correct word and never both high.
6. **Mid-flight reset:** a load is accepted, then reset is pulsed asynchronously between edges -> d_rvalid_o stays 0 after release and starve_cnt restarts from 0.

Source files
------------

// File: rtl/ucsbece154a_mem_arbiter_if.sv
// Core-side request/response and memory-side signals shared by the fetch/data arbiter.
// The slave modport is the arbiter's view; master is the core + memory environment.
interface ucsbece154a_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  i_req_i;
  logic [ADDR_WIDTH-1:0] i_addr_i;
  logic                  i_ready_o;
  logic                  i_rvalid_o;
  logic [DATA_WIDTH-1:0] i_rdata_o;

  logic                  d_req_i;
  logic                  d_we_i;
  logic [ADDR_WIDTH-1:0] d_addr_i;
  logic [DATA_WIDTH-1:0] d_wdata_i;
  logic                  d_ready_o;
  logic                  d_rvalid_o;
  logic [DATA_WIDTH-1:0] d_rdata_o;

  logic                  mem_en_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport slave (
    input  i_req_i, i_addr_i,
    output i_ready_o, i_rvalid_o, i_rdata_o,
    input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
    output d_ready_o, d_rvalid_o, d_rdata_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output i_req_i, i_addr_i,
    input  i_ready_o, i_rvalid_o, i_rdata_o,
    output d_req_i, d_we_i, d_addr_i, d_wdata_i,
    input  d_ready_o, d_rvalid_o, d_rdata_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/ucsbece154a_mem_arbiter.sv
// Shares one single-port synchronous RAM between fetch and load/store; data wins,
// but a pending fetch is granted after at most MAX_DATA_BURST consecutive data grants.
module ucsbece154a_mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_DATA_BURST = 3
) (
  input logic clk,
  input logic reset,
  ucsbece154a_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_I    = 2'd1,
    RESP_D    = 2'd2
  } resp_t;

  resp_t     resp;
  logic [3:0] starve_cnt;

  logic                  grant_i;
  logic                  grant_d;
  logic                  starved;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;

  assign starved = (starve_cnt == 4'(MAX_DATA_BURST));

  // Grants are forced off during reset so every output reads 0 while it is held.
  always_comb begin
    grant_d = !reset && bus.d_req_i && !(bus.i_req_i && starved);
    grant_i = !reset && bus.i_req_i && !grant_d;
  end

  always_comb begin
    sel_addr = '0;
    if (grant_d)
      sel_addr = bus.d_addr_i;
    else if (grant_i)
      sel_addr = bus.i_addr_i;
  end

  assign wdata = reset ? '0 : bus.d_wdata_i;
  assign rdata = reset ? '0 : bus.mem_rdata_i;

  assign bus.i_ready_o   = grant_i;
  assign bus.d_ready_o   = grant_d;
  assign bus.mem_en_o    = grant_i | grant_d;
  assign bus.mem_we_o    = grant_d & bus.d_we_i;
  assign bus.mem_addr_o  = sel_addr;
  assign bus.mem_wdata_o = wdata;

  assign bus.i_rvalid_o = (resp == RESP_I);
  assign bus.d_rvalid_o = (resp == RESP_D);
  assign bus.i_rdata_o  = rdata;
  assign bus.d_rdata_o  = rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp       <= RESP_NONE;
      starve_cnt <= 4'd0;
    end else begin
      if (grant_i)
        resp <= RESP_I;
      else if (grant_d && !bus.d_we_i)
        resp <= RESP_D;
      else
        resp <= RESP_NONE;

      if (!bus.i_req_i || grant_i)
        starve_cnt <= 4'd0;
      else if (grant_d && !starved)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_ucsbece154a_mem_arbiter.sv
// Directed bench for the fetch/data memory arbiter with a small synchronous RAM model.
module tb_ucsbece154a_mem_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  ucsbece154a_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  ucsbece154a_mem_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .MAX_DATA_BURST(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Read-first single-port RAM, word indexed by addr[7:2].
  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (bus.mem_en_o) begin
      if (bus.mem_we_o)
        mem[bus.mem_addr_o[7:2]] <= bus.mem_wdata_o;
      bus.mem_rdata_i <= mem[bus.mem_addr_o[7:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_i_ready"},   32'(bus.i_ready_o),  32'd0);
    chk({tag, "_d_ready"},   32'(bus.d_ready_o),  32'd0);
    chk({tag, "_i_rvalid"},  32'(bus.i_rvalid_o), 32'd0);
    chk({tag, "_d_rvalid"},  32'(bus.d_rvalid_o), 32'd0);
    chk({tag, "_i_rdata"},   bus.i_rdata_o,       32'd0);
    chk({tag, "_d_rdata"},   bus.d_rdata_o,       32'd0);
    chk({tag, "_mem_en"},    32'(bus.mem_en_o),   32'd0);
    chk({tag, "_mem_we"},    32'(bus.mem_we_o),   32'd0);
    chk({tag, "_mem_addr"},  bus.mem_addr_o,      32'd0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata_o,     32'd0);
  endtask

  initial begin
    logic exp_i;
    logic prev_i;
    logic prev_d;
    checks = 0;
    errors = 0;
    for (int k = 0; k < 64; k++) mem[k] = 32'hA000_0000 + 32'(k);
    mem[4] = 32'h0050_0113;
    bus.mem_rdata_i = 32'h1234_5678;

    // Reset held with both requesters active: everything must read 0.
    reset         = 1'b1;
    bus.i_req_i   = 1'b1;
    bus.i_addr_i  = 32'h0000_0010;
    bus.d_req_i   = 1'b1;
    bus.d_we_i    = 1'b1;
    bus.d_addr_i  = 32'h0000_0068;
    bus.d_wdata_i = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    #1 all_zero("rst");

    // Release: a lone load is granted in the very first cycle.
    @(negedge clk);
    reset       = 1'b0;
    bus.i_req_i = 1'b0;
    bus.d_we_i  = 1'b0;
    bus.d_addr_i = 32'h0000_0040;
    #1;
    chk("rel_d_ready", 32'(bus.d_ready_o), 32'd1);
    chk("rel_i_ready", 32'(bus.i_ready_o), 32'd0);
    chk("rel_mem_addr", bus.mem_addr_o, 32'h0000_0040);
    @(negedge clk);
    bus.d_req_i = 1'b0;
    #1;
    chk("rel_d_rvalid", 32'(bus.d_rvalid_o), 32'd1);
    chk("rel_d_rdata", bus.d_rdata_o, 32'hA000_0010);
    chk("idle_mem_en", 32'(bus.mem_en_o), 32'd0);

    // Lone fetch.
    @(negedge clk);
    bus.i_req_i  = 1'b1;
    bus.i_addr_i = 32'h0000_0010;
    #1;
    chk("f_i_ready", 32'(bus.i_ready_o), 32'd1);
    chk("f_d_ready", 32'(bus.d_ready_o), 32'd0);
    chk("f_mem_addr", bus.mem_addr_o, 32'h0000_0010);
    chk("f_mem_we", 32'(bus.mem_we_o), 32'd0);
    @(negedge clk);
    bus.i_req_i = 1'b0;
    #1;
    chk("f_i_rvalid", 32'(bus.i_rvalid_o), 32'd1);
    chk("f_i_rdata", bus.i_rdata_o, 32'h0050_0113);
    chk("f_d_rvalid", 32'(bus.d_rvalid_o), 32'd0);

    // Store then load to the same address.
    @(negedge clk);
    bus.d_req_i   = 1'b1;
    bus.d_we_i    = 1'b1;
    bus.d_addr_i  = 32'h0000_0068;
    bus.d_wdata_i = 32'h0BEE_F000;
    #1;
    chk("st_d_ready", 32'(bus.d_ready_o), 32'd1);
    chk("st_mem_we", 32'(bus.mem_we_o), 32'd1);
    chk("st_mem_wdata", bus.mem_wdata_o, 32'h0BEE_F000);
    @(negedge clk);
    bus.d_we_i = 1'b0;
    #1;
    chk("ld_d_ready", 32'(bus.d_ready_o), 32'd1);
    chk("ld_mem_we", 32'(bus.mem_we_o), 32'd0);
    chk("st_no_rvalid", 32'(bus.d_rvalid_o), 32'd0);
    @(negedge clk);
    bus.d_req_i = 1'b0;
    #1;
    chk("ld_d_rvalid", 32'(bus.d_rvalid_o), 32'd1);
    chk("ld_d_rdata", bus.d_rdata_o, 32'h0BEE_F000);

    // Starvation bound: D,D,D,I repeating with both requests held.
    @(negedge clk);
    bus.i_req_i  = 1'b1;
    bus.i_addr_i = 32'h0000_0020;
    bus.d_req_i  = 1'b1;
    bus.d_addr_i = 32'h0000_0030;
    prev_i = 1'b0;
    prev_d = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      exp_i = ((c % 4) == 3);
      chk($sformatf("sv_i_ready_%0d", c), 32'(bus.i_ready_o), 32'(exp_i));
      chk($sformatf("sv_d_ready_%0d", c), 32'(bus.d_ready_o), 32'(!exp_i));
      chk($sformatf("sv_i_rvalid_%0d", c), 32'(bus.i_rvalid_o), 32'(prev_i));
      chk($sformatf("sv_d_rvalid_%0d", c), 32'(bus.d_rvalid_o), 32'(prev_d));
      if (prev_i) chk($sformatf("sv_i_rdata_%0d", c), bus.i_rdata_o, 32'hA000_0008);
      if (prev_d) chk($sformatf("sv_d_rdata_%0d", c), bus.d_rdata_o, 32'hA000_000C);
      prev_i = exp_i;
      prev_d = !exp_i;
    end
    @(negedge clk);
    bus.i_req_i = 1'b0;
    bus.d_req_i = 1'b0;
    #1;
    chk("sv_last_i_rvalid", 32'(bus.i_rvalid_o), 32'd1);
    chk("sv_last_i_rdata", bus.i_rdata_o, 32'hA000_0008);

    // Alternating responses: fetch then load.
    @(negedge clk);
    bus.i_req_i  = 1'b1;
    bus.i_addr_i = 32'h0000_0024;
    #1 chk("alt_i_ready", 32'(bus.i_ready_o), 32'd1);
    @(negedge clk);
    bus.i_req_i  = 1'b0;
    bus.d_req_i  = 1'b1;
    bus.d_addr_i = 32'h0000_0034;
    #1;
    chk("alt_d_ready", 32'(bus.d_ready_o), 32'd1);
    chk("alt_i_rvalid", 32'(bus.i_rvalid_o), 32'd1);
    chk("alt_i_rdata", bus.i_rdata_o, 32'hA000_0009);
    chk("alt_d_rvalid0", 32'(bus.d_rvalid_o), 32'd0);
    @(negedge clk);
    bus.d_req_i = 1'b0;
    #1;
    chk("alt_d_rvalid", 32'(bus.d_rvalid_o), 32'd1);
    chk("alt_d_rdata", bus.d_rdata_o, 32'hA000_000D);
    chk("alt_i_rvalid0", 32'(bus.i_rvalid_o), 32'd0);

    // Mid-flight reset after two data grants with a fetch pending.
    @(negedge clk);
    bus.i_req_i  = 1'b1;
    bus.i_addr_i = 32'h0000_0020;
    bus.d_req_i  = 1'b1;
    bus.d_addr_i = 32'h0000_0038;
    #1 chk("mf_d_ready0", 32'(bus.d_ready_o), 32'd1);
    @(negedge clk);
    #1 chk("mf_d_ready1", 32'(bus.d_ready_o), 32'd1);
    @(posedge clk);
    #2;
    reset       = 1'b1;
    bus.i_req_i = 1'b0;
    bus.d_req_i = 1'b0;
    #1 all_zero("mf");
    reset = 1'b0;
    @(negedge clk);
    #1 chk("mf_no_rvalid", 32'(bus.d_rvalid_o), 32'd0);
    @(negedge clk);
    bus.i_req_i = 1'b1;
    bus.d_req_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      exp_i = (c == 3);
      chk($sformatf("mf_i_ready_%0d", c), 32'(bus.i_ready_o), 32'(exp_i));
      chk($sformatf("mf_d_ready_%0d", c), 32'(bus.d_ready_o), 32'(!exp_i));
    end
    @(negedge clk);
    bus.i_req_i = 1'b0;
    bus.d_req_i = 1'b0;
    #1 chk("mf_i_rvalid", 32'(bus.i_rvalid_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
